// File: rtl/lcd_frame_writer.sv
// Streams a 32-character screen template from a synchronous ROM to a 16x2 HD44780-class LCD
// over an 8-bit bus. Live fields (address, mode, keypad data, memory data) are substituted into
// fixed slots from a per-frame snapshot. Power-up wait and LCD init run once after reset, then
// frames refresh forever.
module lcd_frame_writer #(
  parameter int unsigned EN_HIGH_CYCLES      = 25,
  parameter int unsigned CMD_WAIT_CYCLES     = 2500,
  parameter int unsigned CLEAR_WAIT_CYCLES   = 100000,
  parameter int unsigned POWERUP_WAIT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] addrIn,
  input  logic       writeMode,
  input  logic [7:0] dataIn,
  input  logic [7:0] dataMem,
  output logic [4:0] romAddr,
  input  logic [7:0] romData,
  output logic       lcdRs,
  output logic       lcdRw,
  output logic       lcdEn,
  output logic [7:0] lcdData,
  output logic       ready,
  output logic       frameDone
);

  localparam int unsigned MaxAb   = (EN_HIGH_CYCLES > CMD_WAIT_CYCLES) ?
                                    EN_HIGH_CYCLES : CMD_WAIT_CYCLES;
  localparam int unsigned MaxCd   = (CLEAR_WAIT_CYCLES > POWERUP_WAIT_CYCLES) ?
                                    CLEAR_WAIT_CYCLES : POWERUP_WAIT_CYCLES;
  localparam int unsigned MaxWait = (MaxAb > MaxCd) ? MaxAb : MaxCd;
  localparam int unsigned CntW    = $clog2(MaxWait + 1);

  typedef logic [CntW-1:0] cnt_t;

  // Counters run 0..N-1, so the terminal value of each phase is N-1.
  localparam cnt_t EnLast    = cnt_t'(EN_HIGH_CYCLES - 1);
  localparam cnt_t CmdLast   = cnt_t'(CMD_WAIT_CYCLES - 1);
  localparam cnt_t ClearLast = cnt_t'(CLEAR_WAIT_CYCLES - 1);
  localparam cnt_t PwrLast   = cnt_t'(POWERUP_WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    StPwrup, StFrame, StFetch, StLoad, StSetup, StEnHigh, StWait, StDone
  } state_t;

  // What the transfer currently in flight is, so the wait phase knows where to go next.
  typedef enum logic [1:0] {KindInit, KindRow, KindChar} kind_t;

  state_t     state_q, state_d;
  kind_t      kind_q, kind_d;
  cnt_t       cnt_q, cnt_d;
  logic [1:0] init_idx_q, init_idx_d;
  logic [4:0] char_q, char_d;
  logic [4:0] rom_addr_q, rom_addr_d;
  logic       rs_q, rs_d;
  logic [7:0] data_q, data_d;
  logic       ready_q, ready_d;
  logic [4:0] snap_addr_q, snap_addr_d;
  logic       snap_wm_q, snap_wm_d;
  logic [7:0] snap_din_q, snap_din_d;
  logic [7:0] snap_dmem_q, snap_dmem_d;

  logic [7:0] sub_byte;
  logic [4:0] tens, ones;
  logic       is_clear;
  cnt_t       wait_last;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    unique case (idx)
      2'd0:    cmd = 8'h38;
      2'd1:    cmd = 8'h0C;
      2'd2:    cmd = 8'h06;
      default: cmd = 8'h01;
    endcase
    return cmd;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Replace template bytes in the live-field slots with snapshot-derived characters.
  always_comb begin
    tens = snap_addr_q / 5'd10;
    ones = snap_addr_q % 5'd10;
    case (char_q)
      5'd4:    sub_byte = 8'h30 + {3'b000, tens};
      5'd5:    sub_byte = 8'h30 + {3'b000, ones};
      5'd14:   sub_byte = snap_wm_q ? 8'h57 : 8'h52;
      5'd20:   sub_byte = hex_char(snap_din_q[7:4]);
      5'd21:   sub_byte = hex_char(snap_din_q[3:0]);
      5'd29:   sub_byte = hex_char(snap_dmem_q[7:4]);
      5'd30:   sub_byte = hex_char(snap_dmem_q[3:0]);
      default: sub_byte = romData;
    endcase
  end

  // Sequencer: power-up, init commands, then the endless frame refresh loop.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    cnt_d       = cnt_q;
    init_idx_d  = init_idx_q;
    char_d      = char_q;
    rom_addr_d  = rom_addr_q;
    rs_d        = rs_q;
    data_d      = data_q;
    ready_d     = ready_q;
    snap_addr_d = snap_addr_q;
    snap_wm_d   = snap_wm_q;
    snap_din_d  = snap_din_q;
    snap_dmem_d = snap_dmem_q;
    is_clear    = !rs_q && (data_q == 8'h01);
    wait_last   = is_clear ? ClearLast : CmdLast;

    unique case (state_q)
      StPwrup: begin
        if (cnt_q == PwrLast) begin
          cnt_d      = '0;
          kind_d     = KindInit;
          init_idx_d = 2'd0;
          rs_d       = 1'b0;
          data_d     = init_cmd(2'd0);
          state_d    = StSetup;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      StFrame: begin
        snap_addr_d = addrIn;
        snap_wm_d   = writeMode;
        snap_din_d  = dataIn;
        snap_dmem_d = dataMem;
        char_d      = 5'd0;
        kind_d      = KindRow;
        rs_d        = 1'b0;
        data_d      = 8'h80;
        state_d     = StSetup;
      end
      StFetch: begin
        state_d = StLoad;
      end
      StLoad: begin
        kind_d  = KindChar;
        rs_d    = 1'b1;
        data_d  = sub_byte;
        state_d = StSetup;
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StEnHigh;
      end
      StEnHigh: begin
        if (cnt_q == EnLast) begin
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      StWait: begin
        if (cnt_q == wait_last) begin
          cnt_d = '0;
          unique case (kind_q)
            KindInit: begin
              if (init_idx_q == 2'd3) begin
                ready_d = 1'b1;
                state_d = StFrame;
              end else begin
                init_idx_d = init_idx_q + 2'd1;
                data_d     = init_cmd(init_idx_q + 2'd1);
                state_d    = StSetup;
              end
            end
            KindRow: begin
              rom_addr_d = char_q;
              state_d    = StFetch;
            end
            KindChar: begin
              if (char_q == 5'd15) begin
                char_d  = 5'd16;
                kind_d  = KindRow;
                rs_d    = 1'b0;
                data_d  = 8'hC0;
                state_d = StSetup;
              end else if (char_q == 5'd31) begin
                state_d = StDone;
              end else begin
                char_d     = char_q + 5'd1;
                rom_addr_d = char_q + 5'd1;
                state_d    = StFetch;
              end
            end
            default: state_d = StFrame;
          endcase
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      StDone: begin
        state_d = StFrame;
      end
      default: state_d = StPwrup;
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StPwrup;
      kind_q      <= KindInit;
      cnt_q       <= '0;
      init_idx_q  <= 2'd0;
      char_q      <= 5'd0;
      rom_addr_q  <= 5'd0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      ready_q     <= 1'b0;
      snap_addr_q <= 5'd0;
      snap_wm_q   <= 1'b0;
      snap_din_q  <= 8'h00;
      snap_dmem_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      cnt_q       <= cnt_d;
      init_idx_q  <= init_idx_d;
      char_q      <= char_d;
      rom_addr_q  <= rom_addr_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      snap_addr_q <= snap_addr_d;
      snap_wm_q   <= snap_wm_d;
      snap_din_q  <= snap_din_d;
      snap_dmem_q <= snap_dmem_d;
    end
  end

  assign romAddr   = rom_addr_q;
  assign lcdRs     = rs_q;
  assign lcdRw     = 1'b0;
  assign lcdEn     = (state_q == StEnHigh);
  assign lcdData   = data_q;
  assign ready     = ready_q;
  assign frameDone = (state_q == StDone);

endmodule
